// File: rtl/double_unit_arbiter.sv
// Round-robin arbiter sharing one doubling datapath (out = in << 1) between NUM_REQ requesters.
// Define DOUBLE_UNIT_SATURATE_EN to clamp overflowing results to all ones instead of truncating.
module double_unit_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned ID_W    = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      rsp_valid,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      rsp_ovf,
    input  logic                      rsp_ready
);

    typedef enum logic [0:0] {StIdle, StResp} state_t;

    state_t            state;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   idx;
    logic [ID_W-1:0]   win;
    logic [ID_W-1:0]   next_ptr;
    logic              found;
    logic [DATA_W-1:0] win_data;
    logic [DATA_W-1:0] dbl_data;
    logic [DATA_W-1:0] ops [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_ops
        assign ops[i] = req_data[i*DATA_W +: DATA_W];
    end

    // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = ID_W'((32'(rr_ptr) + k) % NUM_REQ);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    assign win_data = ops[win];
    assign next_ptr = (win == ID_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;

`ifdef DOUBLE_UNIT_SATURATE_EN
    assign dbl_data = win_data[DATA_W-1] ? '1 : {win_data[DATA_W-2:0], 1'b0};
`else
    assign dbl_data = {win_data[DATA_W-2:0], 1'b0};
`endif

    // Grant is combinational in IDLE; held low while reset is asserted.
    always_comb begin
        req_ready = '0;
        if (rst_n && state == StIdle && found) begin
            req_ready[win] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StIdle;
            rr_ptr    <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            rsp_ovf   <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (found) begin
                        rsp_data  <= dbl_data;
                        rsp_ovf   <= win_data[DATA_W-1];
                        rsp_id    <= win;
                        rsp_valid <= 1'b1;
                        rr_ptr    <= next_ptr;
                        state     <= StResp;
                    end
                end
                StResp: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
